// File: rtl/mcalu.sv
// Multi-cycle ALU execute unit: single-cycle simple ops, iterative shift-add
// multiply and restoring divide, registered result with valid/stall handshake.
module mcalu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exers_mcalu_issue,
  input  logic [4:0]      exers_mcalu_op,
  input  logic [6:0]      exers_robid,
  input  logic [5:0]      exers_rd,
  input  logic [XLEN-1:0] exers_op1,
  input  logic [XLEN-1:0] exers_op2,
  output logic            mcalu_stall,
  output logic            mcalu_valid,
  output logic            mcalu_error,
  output logic [6:0]      mcalu_robid,
  output logic [5:0]      mcalu_rd,
  output logic [XLEN-1:0] mcalu_result,
  input  logic            wb_mcalu_stall,
  input  logic            rob_flush
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   alu_res;
  logic              sa, sb, op_neg, div_special;
  logic [XLEN-1:0]   mag1, mag2;

  // multiply: p holds {accumulator, remaining multiplier bits}
  logic [XLEN-1:0]   a;
  logic [2*XLEN-1:0] p, p_step, prod_fix;
  logic [XLEN:0]     sum;
  logic              neg, hi_sel;

  // divide: r is the partial remainder, q shifts dividend out and quotient in
  logic [XLEN-1:0]   d, r, q, r_step, q_step, q_fix, r_fix;
  logic [XLEN:0]     shifted;
  logic              take, neg_q, neg_r, rem_sel;

  logic [CW-1:0]     sh;

  assign mcalu_stall = (state != IDLE);
  assign mcalu_valid = (state == DONE);
  assign mcalu_error = 1'b0;
  assign sh = exers_op2[CW-1:0];

  always_comb begin
    alu_res = '0;
    case (exers_mcalu_op[3:0])
      4'b0000: alu_res = exers_op1 + exers_op2;
      4'b1000: alu_res = exers_op1 - exers_op2;
      4'b0001: alu_res = exers_op1 << sh;
      4'b0010: alu_res = XLEN'($signed(exers_op1) < $signed(exers_op2));
      4'b0011: alu_res = XLEN'(exers_op1 < exers_op2);
      4'b0100: alu_res = exers_op1 ^ exers_op2;
      4'b0101: alu_res = exers_op1 >> sh;
      4'b1101: alu_res = $unsigned($signed(exers_op1) >>> sh);
      4'b0110: alu_res = exers_op1 | exers_op2;
      4'b0111: alu_res = exers_op1 & exers_op2;
      default: alu_res = '0;
    endcase
  end

  // Operand signedness shared by multiply (MULH/MULHSU) and divide (DIV/REM)
  always_comb begin
    sa = exers_mcalu_op[2] ? ~exers_mcalu_op[0] : (exers_mcalu_op[1] ^ exers_mcalu_op[0]);
    sb = exers_mcalu_op[2] ? ~exers_mcalu_op[0] : (exers_mcalu_op[1:0] == 2'b01);
    mag1 = (sa && exers_op1[XLEN-1]) ? '0 - exers_op1 : exers_op1;
    mag2 = (sb && exers_op2[XLEN-1]) ? '0 - exers_op2 : exers_op2;
    op_neg = (sa & exers_op1[XLEN-1]) ^ (sb & exers_op2[XLEN-1]);
    div_special = (exers_op2 == '0) ||
                  (sa && exers_op1 == MIN_NEG && exers_op2 == '1);
  end

  always_comb begin
    sum      = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, a} : '0);
    p_step   = {sum, p[XLEN-1:1]};
    prod_fix = neg ? '0 - p_step : p_step;
    shifted  = {r, q[XLEN-1]};
    take     = (shifted >= {1'b0, d});
    r_step   = take ? shifted[XLEN-1:0] - d : shifted[XLEN-1:0];
    q_step   = {q[XLEN-2:0], take};
    q_fix    = neg_q ? '0 - q_step : q_step;
    r_fix    = neg_r ? '0 - r_step : r_step;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (exers_mcalu_issue) begin
        if (!exers_mcalu_op[4])      state_next = DONE;
        else if (!exers_mcalu_op[2]) state_next = MUL;
        else if (div_special)        state_next = DONE;
        else                         state_next = DIV;
      end
      MUL, DIV: if (cnt == LAST) state_next = DONE;
      DONE:     if (!wb_mcalu_stall) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (rst || rob_flush) state_next = IDLE;
  end

  always_ff @(posedge clk) state <= state_next;

  always_ff @(posedge clk) begin
    if (rst || rob_flush) begin
      mcalu_robid  <= '0;
      mcalu_rd     <= '0;
      mcalu_result <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: if (exers_mcalu_issue) begin
          mcalu_robid <= exers_robid;
          mcalu_rd    <= exers_rd;
          cnt         <= '0;
          if (!exers_mcalu_op[4]) begin
            mcalu_result <= alu_res;
          end else if (!exers_mcalu_op[2]) begin
            a      <= mag1;
            p      <= {{XLEN{1'b0}}, mag2};
            neg    <= op_neg;
            hi_sel <= (exers_mcalu_op[1:0] != 2'b00);
          end else if (exers_op2 == '0) begin
            mcalu_result <= exers_mcalu_op[1] ? exers_op1 : '1;
          end else if (div_special) begin
            mcalu_result <= exers_mcalu_op[1] ? '0 : MIN_NEG;
          end else begin
            d       <= mag2;
            q       <= mag1;
            r       <= '0;
            neg_q   <= op_neg;
            neg_r   <= sa & exers_op1[XLEN-1];
            rem_sel <= exers_mcalu_op[1];
          end
        end
        MUL: begin
          p   <= p_step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            mcalu_result <= hi_sel ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        end
        DIV: begin
          r   <= r_step;
          q   <= q_step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) mcalu_result <= rem_sel ? r_fix : q_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcalu.sv
// Scoreboard bench for mcalu: directed issues push expectations, a negedge
// monitor pops and checks them when the unit presents a result.
module tb_mcalu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exers_mcalu_issue = 1'b0;
  logic [4:0]  exers_mcalu_op = '0;
  logic [6:0]  exers_robid = '0;
  logic [5:0]  exers_rd = '0;
  logic [31:0] exers_op1 = '0;
  logic [31:0] exers_op2 = '0;
  logic        mcalu_stall, mcalu_valid, mcalu_error;
  logic [6:0]  mcalu_robid;
  logic [5:0]  mcalu_rd;
  logic [31:0] mcalu_result;
  logic        wb_mcalu_stall = 1'b0;
  logic        rob_flush = 1'b0;

  mcalu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .exers_mcalu_issue(exers_mcalu_issue), .exers_mcalu_op(exers_mcalu_op),
    .exers_robid(exers_robid), .exers_rd(exers_rd),
    .exers_op1(exers_op1), .exers_op2(exers_op2),
    .mcalu_stall(mcalu_stall), .mcalu_valid(mcalu_valid), .mcalu_error(mcalu_error),
    .mcalu_robid(mcalu_robid), .mcalu_rd(mcalu_rd), .mcalu_result(mcalu_result),
    .wb_mcalu_stall(wb_mcalu_stall), .rob_flush(rob_flush)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0]  robid;
    logic [5:0]  rd;
    logic [31:0] result;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic seen = 1'b0;
  int checks = 0;
  int passes = 0;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b01000, SLL = 5'b00001,
                         SLT = 5'b00010, SLTU = 5'b00011, XOR = 5'b00100,
                         SRL = 5'b00101, SRA = 5'b01101, OR = 5'b00110;
  localparam logic [4:0] MULL = 5'b10000, MULH = 5'b10001, MULHSU = 5'b10010,
                         MULHU = 5'b10011, DIVS = 5'b10100, DIVU = 5'b10101,
                         REMS = 5'b10110, REMU = 5'b10111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: first valid cycle pops an expectation; further valid cycles must hold it.
  always @(negedge clk) begin
    if (mcalu_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_valid: got result 0x%08h robid 0x%02h with nothing pending (cycle %0d)",
                   mcalu_result, mcalu_robid, cyc);
          cur = '{robid: mcalu_robid, rd: mcalu_rd, result: mcalu_result, due: cyc};
        end else begin
          cur = sb.pop_front();
          chk("latency", cyc, cur.due);
          chk("robid", {25'b0, mcalu_robid}, {25'b0, cur.robid});
          chk("rd", {26'b0, mcalu_rd}, {26'b0, cur.rd});
          chk("result", mcalu_result, cur.result);
          chk("error", {31'b0, mcalu_error}, 32'd0);
        end
      end else begin
        chk("hold_result", mcalu_result, cur.result);
        chk("hold_robid", {25'b0, mcalu_robid}, {25'b0, cur.robid});
        chk("hold_rd", {26'b0, mcalu_rd}, {26'b0, cur.rd});
        chk("hold_stall", {31'b0, mcalu_stall}, 32'd1);
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic drive(input logic [4:0] op, input logic [6:0] id, input logic [5:0] rd,
                       input logic [31:0] x, input logic [31:0] y);
    exers_mcalu_op = op; exers_robid = id; exers_rd = rd;
    exers_op1 = x; exers_op2 = y; exers_mcalu_issue = 1'b1;
  endtask

  // Issue during one cycle t; the result is due in cycle t+lat.
  task automatic issue(input logic [4:0] op, input logic [6:0] id, input logic [5:0] rd,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] res, input int lat);
    @(negedge clk);
    drive(op, id, rd, x, y);
    sb.push_back('{robid: id, rd: rd, result: res, due: cyc + lat});
    @(negedge clk);
    exers_mcalu_issue = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80; i++) begin
      #1;
      if (sb.size() == 0 && !mcalu_valid) return;
      @(negedge clk);
    end
    checks++;
    $display("FAIL wait_idle: got %0d pending results, expected 0 within 80 cycles", sb.size());
    sb.delete();
  endtask

  task automatic run(input logic [4:0] op, input logic [6:0] id, input logic [5:0] rd,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] res, input int lat);
    issue(op, id, rd, x, y, res, lat);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_valid", {31'b0, mcalu_valid}, 32'd0);
    chk("reset_stall", {31'b0, mcalu_stall}, 32'd0);
    chk("reset_result", mcalu_result, 32'd0);
    chk("reset_robid", {25'b0, mcalu_robid}, 32'd0);
    chk("reset_rd", {26'b0, mcalu_rd}, 32'd0);

    // ADD: valid the next cycle with stall high, idle one cycle later
    issue(ADD, 7'h12, 6'h03, 32'd5, 32'hFFFF_FFFE, 32'd3, 1);
    #1;
    chk("add_stall_in_done", {31'b0, mcalu_stall}, 32'd1);
    @(negedge clk); #1;
    chk("add_valid_after", {31'b0, mcalu_valid}, 32'd0);
    chk("add_stall_after", {31'b0, mcalu_stall}, 32'd0);

    run(SUB,  7'h01, 6'h04, 32'd3,          32'd5,          32'hFFFF_FFFE, 1);
    run(SLL,  7'h02, 6'h05, 32'h0000_0001,  32'h0000_0024,  32'h0000_0010, 1);
    run(SRA,  7'h03, 6'h06, 32'h8000_0000,  32'd4,          32'hF800_0000, 1);
    run(SRL,  7'h04, 6'h07, 32'h8000_0000,  32'd31,         32'h0000_0001, 1);
    run(SLT,  7'h05, 6'h08, 32'hFFFF_FFFF,  32'd1,          32'd1,         1);
    run(SLTU, 7'h06, 6'h09, 32'hFFFF_FFFF,  32'd1,          32'd0,         1);
    run(XOR,  7'h07, 6'h25, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0, 1);
    run(5'b01111, 7'h08, 6'h0A, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 1);

    run(MULH,   7'h10, 6'h11, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 33);
    run(MULL,   7'h11, 6'h12, 32'h8000_0000, 32'd2,         32'h0000_0000, 33);
    run(MULHU,  7'h12, 6'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run(MULHSU, 7'h13, 6'h14, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
    run(MULL,   7'h14, 6'h15, 32'd1234,      32'd5678,      32'd7006652,   33);

    run(DIVS, 7'h20, 6'h16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run(REMS, 7'h21, 6'h17, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run(DIVU, 7'h22, 6'h18, 32'd100,       32'd7, 32'd14,        33);
    run(REMU, 7'h23, 6'h19, 32'd100,       32'd7, 32'd2,         33);

    run(DIVU, 7'h30, 6'h1A, 32'd9,         32'd0,         32'hFFFF_FFFF, 1);
    run(REMS, 7'h31, 6'h1B, 32'd9,         32'd0,         32'd9,         1);
    run(DIVS, 7'h32, 6'h1C, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run(REMS, 7'h33, 6'h1D, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Writeback backpressure for 4 cycles in DONE
    wb_mcalu_stall = 1'b1;
    issue(OR, 7'h40, 6'h25, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1);
    repeat (3) @(negedge clk);
    wb_mcalu_stall = 1'b0;
    @(negedge clk); #1;
    chk("bp_release_valid", {31'b0, mcalu_valid}, 32'd0);
    chk("bp_release_stall", {31'b0, mcalu_stall}, 32'd0);

    // Flush at iteration 10 of a DIV: nothing is expected from it
    @(negedge clk);
    drive(DIVU, 7'h50, 6'h01, 32'd1000, 32'd3);
    @(negedge clk);
    exers_mcalu_issue = 1'b0;
    repeat (10) @(negedge clk);
    rob_flush = 1'b1;
    @(negedge clk);
    rob_flush = 1'b0;
    #1;
    chk("flush_stall", {31'b0, mcalu_stall}, 32'd0);
    chk("flush_valid", {31'b0, mcalu_valid}, 32'd0);
    run(ADD, 7'h51, 6'h02, 32'd40, 32'd2, 32'd42, 1);
    repeat (40) @(negedge clk);

    // Issue coincident with reset is dropped
    @(negedge clk);
    drive(ADD, 7'h60, 6'h03, 32'd1, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    exers_mcalu_issue = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_issue_valid", {31'b0, mcalu_valid}, 32'd0);
    chk("rst_issue_stall", {31'b0, mcalu_stall}, 32'd0);
    chk("pending_at_end", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mcalu.md
Name: mcalu

Overview:
Multi-cycle ALU execute unit; two instances (mcalu0, mcalu1) sit directly downstream of the execute reservation station.
- Accepts one issued micro-op at a time: any simple ALU op (op[4]=0) or an RV32M multiply/divide op (op[4]=1).
- Computes the result with an iterative shift-add multiplier or restoring divider.
- Presents a registered result to the writeback arbiter with a valid/stall handshake.
- Asserts stall to the reservation station whenever busy.

Parameters:
XLEN, 32, datapath width; only 32 is supported. Iteration count is XLEN.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
exers_mcalu_issue  input  1  issue strobe from reservation station
exers_mcalu_op  input  5  operation encoding
exers_robid  input  7  ROB id of issued op
exers_rd  input  6  destination tag; bit5=1 means no register write
exers_op1  input  32  source operand 1
exers_op2  input  32  source operand 2
mcalu_stall  output  1  busy; reservation station must not issue
mcalu_valid  output  1  result valid to writeback
mcalu_error  output  1  exception flag; always 0
mcalu_robid  output  7  ROB id of result
mcalu_rd  output  6  destination tag of result
mcalu_result  output  32  result data
wb_mcalu_stall  input  1  writeback arbiter not accepting this cycle
rob_flush  input  1  pipeline flush

Behaviour:
- Op encoding, op[4]=0 (simple), op[3:0]: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111. Shift amount is op2[4:0]. Other codes return 0.
- Op encoding, op[4]=1 (M-ext), op[2:0]: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111. op[3] is ignored.
- States: IDLE, MUL, DIV, DONE.
- Reset/flush values: state=IDLE; mcalu_valid=0, mcalu_error=0, mcalu_robid=0, mcalu_rd=0, mcalu_result=0; iteration counter=0.
- mcalu_stall = (state != IDLE). It is a pure state decode with no combinational path from issue.
- Issue in IDLE, simple op: result latched; next cycle state=DONE, mcalu_valid=1.
- Issue in IDLE, multiply: latch |op1|, |op2|, and result sign per variant (MULH signed×signed, MULHSU signed×unsigned, MULHU/MUL unsigned; MUL low word is sign-agnostic).
  - State=MUL for 32 cycles. Each cycle: one shift-add step on a 64-bit accumulator; counter 0..31.
  - Then DONE. Apply sign negation to the 64-bit product; select low word (MUL) or high word (others).
  - Issue at cycle t gives mcalu_valid at t+33.
- Issue in IDLE, divide: signed variants take magnitudes and record quotient sign (op1^op2 sign) and remainder sign (op1 sign).
  - State=DIV for 32 cycles of restoring division, then DONE with sign fixup. Valid at t+33.
- Divide special cases skip iteration and reach DONE at t+1:
  - op2==0: quotient=0xFFFFFFFF, remainder=op1, for all variants.
  - Signed op1=0x80000000, op2=0xFFFFFFFF: quotient=0x80000000, remainder=0.
- DONE: mcalu_valid=1; robid, rd and result are held stable. When mcalu_valid & ~wb_mcalu_stall, go to IDLE next cycle with valid=0. Otherwise stay in DONE.
- Issue while state!=IDLE is a protocol violation and is ignored.
- Throughput: simple op at most one per 2 cycles; M-ext op one per 34 cycles, both with no wb stall.
- rob_flush or rst in any state: next cycle state=IDLE and valid=0; any in-flight result is discarded.
  - Issue in the same cycle as flush/rst is dropped.
  - rst has priority over every other input.
- Ops with rd[5]=1 are still executed and written back (the ROB needs completion); rd is passed through unchanged.

Test Plan:
- Simple op: ADD op1=5, op2=0xFFFFFFFE, robid=0x12, rd=0x03 -> next cycle valid=1, result=3, robid=0x12, rd=0x03, stall=1. Following cycle valid=0, stall=0.
- Signed multiply: MULH op1=0x80000000, op2=2 -> valid exactly 33 cycles after issue, result=0xFFFFFFFF. MUL with the same operands -> 0x00000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- Signed divide and remainder: DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF, both at t+33.
- Divide special cases: DIVU 9/0 -> 0xFFFFFFFF at t+1; REM 9/0 -> 9; DIV 0x80000000/−1 -> 0x80000000, REM of the same -> 0.
- Writeback backpressure: wb_mcalu_stall=1 for 4 cycles while in DONE -> valid, robid, rd and result held constant and stall=1. Release -> IDLE next cycle.
- Flush and reset mid-operation: rob_flush at iteration 10 of DIV -> valid never rises, stall=0 next cycle, and a new ADD issues and completes correctly. Issue concurrent with rst -> no valid produced.
